// File: rtl/uart_rx_param.sv
// Parametrised UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting instead of a single mid-bit sample.
// Result appears mid+2 cycles into the last stop bit; no backpressure, the consumer must take each pulse.
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN     = PRESCALE_W'(4);
  localparam logic [3:0]            LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]            LAST_STOP = 4'(STOP_BITS - 1);

  state_t                  state, state_nxt;
  logic                    sync1, rx_s, rx_prev;
  logic [PRESCALE_W-1:0]   p_q, edge_cnt, mid, p_ld;
  logic [3:0]              bit_cnt;
  logic [DATA_W-1:0]       shreg;
  logic                    par_en_q, par_typ_q, par_flag, stp_flag;
  logic                    samp_b, bit_dec, dec_cyc, bnd_cyc, start_det;
  logic                    done, stp_now, dv_nxt, pe_nxt, se_nxt, sg_nxt;
`ifdef UART_RX_MAJORITY_EN
  logic                    samp_a;
`endif

  assign p_ld      = (prescale < P_MIN) ? P_MIN : prescale;
  assign mid       = p_q >> 1;
  assign dec_cyc   = (edge_cnt == mid + ONE);
  assign bnd_cyc   = (edge_cnt == p_q - ONE);
  assign start_det = (state == IDLE) && rx_prev && !rx_s;

  // The mid+1 sample is the live rx_s, so the decision lands on the same cycle in both builds.
`ifdef UART_RX_MAJORITY_EN
  assign bit_dec = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
  assign bit_dec = samp_b;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    sg_nxt    = 1'b0;
    case (state)
      IDLE:   if (start_det) state_nxt = START;
      START: begin
        if (dec_cyc && bit_dec) begin
          state_nxt = IDLE;
          sg_nxt    = 1'b1;
        end else if (bnd_cyc) begin
          state_nxt = DATA;
        end
      end
      DATA:   if (bnd_cyc && bit_cnt == LAST_DATA) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (bnd_cyc) state_nxt = STOP;
      // Leave on the last stop decision so a following start edge is caught on time.
      STOP: begin
        if (dec_cyc && bit_cnt == LAST_STOP) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    stp_now = stp_flag | ~bit_dec;
    dv_nxt  = done & ~par_flag & ~stp_now;
    pe_nxt  = done & par_flag;
    se_nxt  = done & stp_now;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      p_q       <= P_MIN;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_flag  <= 1'b0;
      stp_flag  <= 1'b0;
      samp_b    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_a    <= 1'b1;
`endif
    end else begin
      sync1   <= RX_IN;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      if (state == IDLE) begin
        edge_cnt <= start_det ? ONE : '0;
        bit_cnt  <= '0;
        if (start_det) begin
          p_q       <= p_ld;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_flag  <= 1'b0;
          stp_flag  <= 1'b0;
        end
      end else begin
        edge_cnt <= bnd_cyc ? '0 : edge_cnt + ONE;
        if (state_nxt != state) bit_cnt <= '0;
        else if (bnd_cyc)       bit_cnt <= bit_cnt + 4'd1;
`ifdef UART_RX_MAJORITY_EN
        if (edge_cnt == mid - ONE) samp_a <= rx_s;
`endif
        if (edge_cnt == mid) samp_b <= rx_s;
        if (dec_cyc) begin
          case (state)
            DATA:    shreg    <= {bit_dec, shreg[DATA_W-1:1]};
            PARITY:  par_flag <= bit_dec ^ (^shreg) ^ par_typ_q;
            STOP:    if (!bit_dec) stp_flag <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= dv_nxt;
      par_err     <= pe_nxt;
      stp_err     <= se_nxt;
      strt_glitch <= sg_nxt;
      if (done) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three builds (8N1, 8N2, 7-bit) share one serial line and controls.
module tb_uart_rx_param;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP;
  logic [5:0] prescale;
  logic [7:0] pd0, pd1;
  logic [6:0] pd2;
  logic       dv[3], pe[3], se[3], sg[3];
  logic [8:0] pdv[3];

  int total = 0, bad = 0, cyc = 0, ovl = 0, f = 0;
  int n_dv[3] = '{0, 0, 0}, n_pe[3] = '{0, 0, 0}, n_se[3] = '{0, 0, 0}, n_sg[3] = '{0, 0, 0};
  int dv_cyc[3] = '{0, 0, 0};
  logic [8:0] last_pd[3] = '{9'h0, 9'h0, 9'h0}, prev_pd[3] = '{9'h0, 9'h0, 9'h0};
  int b_dv, b_pe, b_se, b_sg;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [8:0] MAJ_EXP = 9'h0FF;
`else
  localparam logic [8:0] MAJ_EXP = 9'h0FB;
`endif

  assign pdv[0] = {1'b0, pd0};
  assign pdv[1] = {1'b0, pd1};
  assign pdv[2] = {2'b0, pd2};

  uart_rx_param #(.DATA_W(8), .PRESCALE_W(6), .STOP_BITS(1)) u_dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .P_DATA(pd0), .data_valid(dv[0]), .par_err(pe[0]), .stp_err(se[0]), .strt_glitch(sg[0]));

  uart_rx_param #(.DATA_W(8), .PRESCALE_W(6), .STOP_BITS(2)) u_dut_2stop (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .P_DATA(pd1), .data_valid(dv[1]), .par_err(pe[1]), .stp_err(se[1]), .strt_glitch(sg[1]));

  uart_rx_param #(.DATA_W(7), .PRESCALE_W(6), .STOP_BITS(1)) u_dut_7bit (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .P_DATA(pd2), .data_valid(dv[2]), .par_err(pe[2]), .stp_err(se[2]), .strt_glitch(sg[2]));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        n_dv[i]++;
        dv_cyc[i]  = cyc;
        prev_pd[i] = last_pd[i];
        last_pd[i] = pdv[i];
      end
      if (pe[i] === 1'b1) n_pe[i]++;
      if (se[i] === 1'b1) n_se[i]++;
      if (sg[i] === 1'b1) n_sg[i]++;
      if (dv[i] === 1'b1 && (pe[i] === 1'b1 || se[i] === 1'b1)) ovl++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic snap(input int i);
    b_dv = n_dv[i];
    b_pe = n_pe[i];
    b_se = n_se[i];
    b_sg = n_sg[i];
  endtask

  // gl: data bit index that gets a one-cycle low pulse at its mid point (-1 for none)
  task automatic send_frame(input logic [8:0] d, input int dw, input int p, input bit has_par,
                            input logic par, input logic [1:0] stops, input int nstop,
                            input int last_len, input int gl);
    RX_IN = 1'b0;
    step(p);
    for (int i = 0; i < dw; i++) begin
      if (i == gl) begin
        RX_IN = 1'b1; step(p / 2);
        RX_IN = 1'b0; step(1);
        RX_IN = 1'b1; step(p - p / 2 - 1);
      end else begin
        RX_IN = d[i];
        step(p);
      end
    end
    if (has_par) begin
      RX_IN = par;
      step(p);
    end
    for (int i = 0; i < nstop; i++) begin
      RX_IN = stops[i];
      step((i == nstop - 1) ? last_len : p);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 6'd8;
    step(3);
    check("rst p_data", {24'h0, pd0}, 32'h0);
    check("rst data_valid", {31'h0, dv[0]}, 32'h0);
    check("rst par_err", {31'h0, pe[0]}, 32'h0);
    check("rst stp_err", {31'h0, se[0]}, 32'h0);
    check("rst strt_glitch", {31'h0, sg[0]}, 32'h0);
    check("rst p_data 7bit", {25'h0, pd2}, 32'h0);
    RST = 1'b0;
    step(4);

    // 0xA5, even parity 0, p=8: latency 2 + 8*10 + 4 + 2
    snap(0); f = cyc;
    send_frame(9'h0A5, 8, 8, 1'b1, 1'b0, 2'b11, 1, 8, -1);
    step(16);
    check("a5 dv", n_dv[0] - b_dv, 1);
    check("a5 p_data", last_pd[0], 9'h0A5);
    check("a5 par_err", n_pe[0] - b_pe, 0);
    check("a5 stp_err", n_se[0] - b_se, 0);
    check("a5 latency", dv_cyc[0] - f, 88);

    snap(0);
    send_frame(9'h0A5, 8, 8, 1'b1, 1'b1, 2'b11, 1, 8, -1);
    step(16);
    check("bad par dv", n_dv[0] - b_dv, 0);
    check("bad par par_err", n_pe[0] - b_pe, 1);
    check("bad par p_data", {24'h0, pd0}, 32'hA5);

    // Truncated stop: next start edge lands the cycle after the frame resolves
    snap(0);
    send_frame(9'h03C, 8, 8, 1'b1, 1'b0, 2'b11, 1, 7, -1);
    send_frame(9'h05A, 8, 8, 1'b1, 1'b0, 2'b11, 1, 8, -1);
    step(16);
    check("tight dv", n_dv[0] - b_dv, 2);
    check("tight first", prev_pd[0], 9'h03C);
    check("tight second", last_pd[0], 9'h05A);

    prescale = 6'd16; PAR_EN = 1'b0;
    step(300);
    snap(1);
    send_frame(9'h03C, 8, 16, 1'b0, 1'b0, 2'b01, 2, 16, -1);
    step(16);
    send_frame(9'h0C3, 8, 16, 1'b0, 1'b0, 2'b11, 2, 16, -1);
    send_frame(9'h05A, 8, 16, 1'b0, 1'b0, 2'b11, 2, 16, -1);
    step(32);
    check("2stop stp_err", n_se[1] - b_se, 1);
    check("2stop dv", n_dv[1] - b_dv, 2);
    check("2stop c3", prev_pd[1], 9'h0C3);
    check("2stop 5a", last_pd[1], 9'h05A);
    check("2stop par_err", n_pe[1] - b_pe, 0);

    prescale = 6'd8; PAR_EN = 1'b1;
    step(300);
    snap(0);
    RX_IN = 1'b0; step(2);
    RX_IN = 1'b1; step(40);
    check("glitch sg", n_sg[0] - b_sg, 1);
    check("glitch others", (n_dv[0] - b_dv) + (n_pe[0] - b_pe) + (n_se[0] - b_se), 0);

    PAR_EN = 1'b0;
    snap(0);
    send_frame(9'h0FF, 8, 8, 1'b0, 1'b0, 2'b11, 1, 8, 2);
    step(16);
    check("midglitch dv", n_dv[0] - b_dv, 1);
    check("midglitch p_data", last_pd[0], MAJ_EXP);

    // 7-bit build: p=10 latency 2 + 10*9 + 5 + 2
    prescale = 6'd10; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    step(300);
    snap(2); f = cyc;
    send_frame(9'h055, 7, 10, 1'b1, 1'b1, 2'b11, 1, 10, -1);
    step(20);
    check("7b dv", n_dv[2] - b_dv, 1);
    check("7b p_data", last_pd[2], 9'h055);
    check("7b par_err", n_pe[2] - b_pe, 0);
    check("7b latency", dv_cyc[2] - f, 99);

    snap(2);
    fork
      send_frame(9'h055, 7, 10, 1'b1, 1'b1, 2'b11, 1, 10, -1);
      begin
        step(35);
        prescale = 6'd4;
      end
    join
    step(20);
    check("7b presc dv", n_dv[2] - b_dv, 1);
    check("7b presc p_data", last_pd[2], 9'h055);
    check("7b presc par_err", n_pe[2] - b_pe, 0);

    prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    step(300);
    RX_IN = 1'b0; step(8);
    RX_IN = 1'b1; step(8);
    RX_IN = 1'b0; step(8);
    RX_IN = 1'b1; step(8);
    RX_IN = 1'b0; step(4);
    RST = 1'b1; RX_IN = 1'b1;
    step(1);
    check("abort p_data", {24'h0, pd0}, 32'h0);
    check("abort pulses", {28'h0, dv[0], pe[0], se[0], sg[0]}, 32'h0);
    RST = 1'b0;
    snap(0);
    step(200);
    check("abort quiet", (n_dv[0] - b_dv) + (n_pe[0] - b_pe) + (n_se[0] - b_se) + (n_sg[0] - b_sg), 0);
    snap(0);
    send_frame(9'h081, 8, 8, 1'b1, 1'b0, 2'b11, 1, 8, -1);
    step(16);
    check("after rst dv", n_dv[0] - b_dv, 1);
    check("after rst p_data", last_pd[0], 9'h081);

    check("exclusive pulses", ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
